// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode-stage hazard control signal bundle
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd;
    logic             id_wb_en;
    logic             id_is_load;
    logic             ex_brn_tkn;
    logic             stall;
    logic             flush;
    logic             bubble_ex;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             rf_byp_a;
    logic             rf_byp_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wb_en, id_is_load, ex_brn_tkn,
        input  stall, flush, bubble_ex, fwd_a_sel, fwd_b_sel,
               rf_byp_a, rf_byp_b, stall_cnt, flush_cnt, retire_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wb_en, id_is_load, ex_brn_tkn,
        output stall, flush, bubble_ex, fwd_a_sel, fwd_b_sel,
               rf_byp_a, rf_byp_b, stall_cnt, flush_cnt, retire_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, redirect flush and forwarding select generation
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wb;
        logic       ld;
    } sb_ent_t;

    sb_ent_t          ex_q, mem_q, wb_q, ex_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, retire_cnt_q;
    logic             lu, redir, stall, flush, bubble;

    // x0 is never a real destination, so it can neither stall nor forward.
    function automatic logic writes(sb_ent_t e, logic [4:0] r);
        return e.v && e.wb && (e.rd != 5'd0) && (e.rd == r);
    endfunction

    // Loads in EX cannot forward; they reach this path only after a stall.
    function automatic logic [1:0] fwd_sel(logic use_r, logic [4:0] r,
                                           sb_ent_t ex, sb_ent_t mem);
        logic [1:0] sel;
        sel = 2'd0;
        if (use_r) begin
            if (writes(ex, r) && !ex.ld)
                sel = 2'd1;
            else if (writes(mem, r))
                sel = 2'd2;
        end
        return sel;
    endfunction

    always_comb begin
        lu = bus.id_valid && ex_q.ld &&
             ((bus.id_use_rs1 && writes(ex_q, bus.id_rs1)) ||
              (bus.id_use_rs2 && writes(ex_q, bus.id_rs2)));
        redir  = bus.ex_brn_tkn && ex_q.v;
        flush  = redir;
        stall  = lu && !redir;
        bubble = lu || redir;

        ex_d.v  = bus.id_valid;
        ex_d.rd = bus.id_rd;
        ex_d.wb = bus.id_wb_en;
        ex_d.ld = bus.id_is_load;
        if (bubble)
            ex_d = '0;

        fwd_a_d = bubble ? 2'd0 : fwd_sel(bus.id_use_rs1, bus.id_rs1, ex_q, mem_q);
        fwd_b_d = bubble ? 2'd0 : fwd_sel(bus.id_use_rs2, bus.id_rs2, ex_q, mem_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            fwd_a_q      <= 2'd0;
            fwd_b_q      <= 2'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            if (stall)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (wb_q.v)
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall      = stall;
    assign bus.flush      = flush;
    assign bus.bubble_ex  = bubble;
    assign bus.fwd_a_sel  = fwd_a_q;
    assign bus.fwd_b_sel  = fwd_b_q;
    assign bus.rf_byp_a   = bus.id_use_rs1 && writes(wb_q, bus.id_rs1);
    assign bus.rf_byp_b   = bus.id_use_rs2 && writes(wb_q, bus.id_rs2);
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
    assign bus.retire_cnt = retire_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scenarios plus randomized run against a queue-based pipeline model
module tb_pipe_hazard_ctrl;
    logic clock;
    logic reset;

    pipe_hazard_ctrl_if #(.CNT_W(32)) hif();

    pipe_hazard_ctrl #(.CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (hif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wb;
        bit       ld;
    } ent_t;

    // sb[0] = EX, sb[1] = MEM, sb[2] = WB
    ent_t        sb[$];
    bit   [1:0]  m_fa, m_fb;
    bit   [31:0] m_stall, m_flush, m_retire;

    function automatic bit m_writes(ent_t e, bit [4:0] r);
        return e.v && e.wb && r != 5'd0 && e.rd == r;
    endfunction

    function automatic bit m_redir();
        return hif.ex_brn_tkn && sb[0].v;
    endfunction

    function automatic bit m_lu();
        return hif.id_valid && sb[0].ld &&
               ((hif.id_use_rs1 && m_writes(sb[0], hif.id_rs1)) ||
                (hif.id_use_rs2 && m_writes(sb[0], hif.id_rs2)));
    endfunction

    function automatic bit [1:0] m_src(bit used, bit [4:0] r);
        if (!used || m_lu() || m_redir()) return 2'd0;
        if (m_writes(sb[0], r) && !sb[0].ld) return 2'd1;
        if (m_writes(sb[1], r)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_clear();
        ent_t z;
        z = '{v: 0, rd: 0, wb: 0, ld: 0};
        sb = {z, z, z};
        m_fa = 0; m_fb = 0;
        m_stall = 0; m_flush = 0; m_retire = 0;
    endtask

    // Advance model and DUT across one rising edge using the inputs currently applied.
    task automatic tick();
        ent_t nx;
        if (reset) begin
            model_clear();
        end else begin
            if (m_lu() && !m_redir()) m_stall++;
            if (m_redir()) m_flush++;
            if (sb[2].v) m_retire++;
            m_fa = m_src(hif.id_use_rs1, hif.id_rs1);
            m_fb = m_src(hif.id_use_rs2, hif.id_rs2);
            if (m_lu() || m_redir())
                nx = '{v: 0, rd: 0, wb: 0, ld: 0};
            else
                nx = '{v: hif.id_valid, rd: hif.id_rd, wb: hif.id_wb_en, ld: hif.id_is_load};
            void'(sb.pop_back());
            sb.push_front(nx);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                          input bit u1, input bit u2, input bit [4:0] rd,
                          input bit wb, input bit ld, input bit br);
        hif.id_valid   = v;
        hif.id_rs1     = rs1;
        hif.id_rs2     = rs2;
        hif.id_use_rs1 = u1;
        hif.id_use_rs2 = u2;
        hif.id_rd      = rd;
        hif.id_wb_en   = wb;
        hif.id_is_load = ld;
        hif.ex_brn_tkn = br;
        @(negedge clock);
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_id(1, 7, 7, 1, 1, 3, 1, 1, 1);
        tick();
        set_id(1, 7, 7, 1, 1, 3, 1, 1, 1);
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", hif.stall); end
        checks++; if (hif.flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %0b want 0", hif.flush); end
        checks++; if (hif.bubble_ex !== 1'b0) begin errors++; $display("FAIL rst_bubble got %0b want 0", hif.bubble_ex); end
        checks++; if (hif.fwd_a_sel !== 2'd0 || hif.fwd_b_sel !== 2'd0) begin errors++; $display("FAIL rst_fwd got %0d/%0d want 0/0", hif.fwd_a_sel, hif.fwd_b_sel); end
        checks++; if (hif.stall_cnt !== 0 || hif.flush_cnt !== 0 || hif.retire_cnt !== 0) begin errors++; $display("FAIL rst_cnt got %0d/%0d/%0d want 0/0/0", hif.stall_cnt, hif.flush_cnt, hif.retire_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_alu_fwd();
        do_reset();
        set_id(1, 0, 0, 1, 0, 5, 1, 0, 0);
        tick();
        set_id(1, 5, 5, 1, 1, 6, 1, 0, 0);
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %0b want 0", hif.stall); end
        tick();
        nop();
        checks++; if (hif.fwd_a_sel !== 2'd1) begin errors++; $display("FAIL alu_fwd_a got %0d want 1", hif.fwd_a_sel); end
        checks++; if (hif.fwd_b_sel !== 2'd1) begin errors++; $display("FAIL alu_fwd_b got %0d want 1", hif.fwd_b_sel); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 1, 0, 1, 0, 7, 1, 1, 0);
        tick();
        set_id(1, 7, 0, 1, 1, 8, 1, 0, 0);
        checks++; if (hif.stall !== 1'b1 || hif.bubble_ex !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b/%0b want 1/1", hif.stall, hif.bubble_ex); end
        tick();
        set_id(1, 7, 0, 1, 1, 8, 1, 0, 0);
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got %0b want 0", hif.stall); end
        tick();
        nop();
        checks++; if (hif.fwd_a_sel !== 2'd2 || hif.fwd_b_sel !== 2'd0) begin errors++; $display("FAIL lu_fwd got %0d/%0d want 2/0", hif.fwd_a_sel, hif.fwd_b_sel); end
        checks++; if (hif.stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", hif.stall_cnt); end
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        set_id(1, 1, 0, 1, 0, 7, 1, 1, 0);
        tick();
        set_id(1, 7, 1, 1, 1, 8, 1, 0, 1);
        checks++; if (hif.flush !== 1'b1 || hif.bubble_ex !== 1'b1 || hif.stall !== 1'b0) begin errors++; $display("FAIL redir_out got f%0b b%0b s%0b want f1 b1 s0", hif.flush, hif.bubble_ex, hif.stall); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++; if (hif.flush !== 1'b0) begin errors++; $display("FAIL redir_inv_ex got %0b want 0", hif.flush); end
        checks++; if (hif.flush_cnt !== 32'd1 || hif.stall_cnt !== 32'd0) begin errors++; $display("FAIL redir_cnt got %0d/%0d want 1/0", hif.flush_cnt, hif.stall_cnt); end
        tick();
    endtask

    task automatic test_x0_unused();
        do_reset();
        set_id(1, 1, 0, 1, 0, 0, 1, 1, 0);
        tick();
        set_id(1, 0, 0, 1, 1, 9, 1, 0, 0);
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %0b want 0", hif.stall); end
        tick();
        set_id(1, 0, 0, 1, 0, 12, 1, 1, 0);
        checks++; if (hif.fwd_a_sel !== 2'd0 || hif.fwd_b_sel !== 2'd0) begin errors++; $display("FAIL x0_fwd got %0d/%0d want 0/0", hif.fwd_a_sel, hif.fwd_b_sel); end
        tick();
        set_id(1, 12, 12, 0, 0, 10, 1, 0, 0);
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL unused_stall got %0b want 0", hif.stall); end
        tick();
        nop();
        checks++; if (hif.fwd_a_sel !== 2'd0 || hif.fwd_b_sel !== 2'd0) begin errors++; $display("FAIL unused_fwd got %0d/%0d want 0/0", hif.fwd_a_sel, hif.fwd_b_sel); end
        tick();
    endtask

    task automatic test_priority_bypass();
        do_reset();
        set_id(1, 0, 0, 1, 0, 3, 1, 0, 0);
        tick();
        set_id(1, 0, 0, 1, 0, 3, 1, 0, 0);
        tick();
        set_id(1, 3, 3, 1, 1, 4, 1, 0, 0);
        tick();
        nop();
        checks++; if (hif.fwd_a_sel !== 2'd1 || hif.fwd_b_sel !== 2'd1) begin errors++; $display("FAIL prio_fwd got %0d/%0d want 1/1", hif.fwd_a_sel, hif.fwd_b_sel); end
        set_id(1, 0, 0, 1, 0, 11, 1, 0, 0);
        tick();
        nop();
        tick();
        nop();
        tick();
        set_id(1, 11, 2, 1, 1, 13, 1, 0, 0);
        checks++; if (hif.rf_byp_a !== 1'b1 || hif.rf_byp_b !== 1'b0) begin errors++; $display("FAIL byp got %0b/%0b want 1/0", hif.rf_byp_a, hif.rf_byp_b); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            set_id(1, 0, 0, 0, 0, 5'(i), 1, 0, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            nop();
            tick();
        end
        nop();
        checks++; if (hif.retire_cnt !== 32'd10) begin errors++; $display("FAIL retire10 got %0d want 10", hif.retire_cnt); end
        set_id(1, 0, 0, 1, 0, 5, 1, 1, 0);
        tick();
        set_id(1, 5, 0, 1, 0, 6, 1, 0, 0);
        checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL mid_stall got %0b want 1", hif.stall); end
        reset = 1'b1;
        tick();
        set_id(1, 5, 0, 1, 0, 6, 1, 0, 0);
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got %0b want 0", hif.stall); end
        checks++; if (hif.stall_cnt !== 0 || hif.flush_cnt !== 0 || hif.retire_cnt !== 0) begin errors++; $display("FAIL mid_rst_cnt got %0d/%0d/%0d want 0/0/0", hif.stall_cnt, hif.flush_cnt, hif.retire_cnt); end
        checks++; if (hif.fwd_a_sel !== 2'd0 || hif.fwd_b_sel !== 2'd0) begin errors++; $display("FAIL mid_rst_fwd got %0d/%0d want 0/0", hif.fwd_a_sel, hif.fwd_b_sel); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit [1:0] exp_fa, exp_fb;
        bit       exp_s, exp_f, exp_b, exp_ba, exp_bb;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 79) == 0);
            set_id($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 5) == 0);
            exp_s  = m_lu() && !m_redir();
            exp_f  = m_redir();
            exp_b  = m_lu() || m_redir();
            exp_ba = hif.id_use_rs1 && m_writes(sb[2], hif.id_rs1);
            exp_bb = hif.id_use_rs2 && m_writes(sb[2], hif.id_rs2);
            exp_fa = m_fa;
            exp_fb = m_fb;
            checks++; if ({hif.stall, hif.flush, hif.bubble_ex} !== {exp_s, exp_f, exp_b}) begin errors++; $display("FAIL rnd_ctl cyc %0d got %03b want %03b", n, {hif.stall, hif.flush, hif.bubble_ex}, {exp_s, exp_f, exp_b}); end
            checks++; if ({hif.fwd_a_sel, hif.fwd_b_sel} !== {exp_fa, exp_fb}) begin errors++; $display("FAIL rnd_fwd cyc %0d got %0d/%0d want %0d/%0d", n, hif.fwd_a_sel, hif.fwd_b_sel, exp_fa, exp_fb); end
            checks++; if ({hif.rf_byp_a, hif.rf_byp_b} !== {exp_ba, exp_bb}) begin errors++; $display("FAIL rnd_byp cyc %0d got %0b%0b want %0b%0b", n, hif.rf_byp_a, hif.rf_byp_b, exp_ba, exp_bb); end
            checks++; if (hif.stall_cnt !== m_stall || hif.flush_cnt !== m_flush || hif.retire_cnt !== m_retire) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d", n, hif.stall_cnt, hif.flush_cnt, hif.retire_cnt, m_stall, m_flush, m_retire); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        model_clear();
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_redirect();
        test_x0_unused();
        test_priority_bypass();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequences the five-stage pipeline around the decode/control stage.
- Keeps its own shadow scoreboard of the instructions in EX, MEM and WB (valid, rd, write-back enable, load flag).
- From that scoreboard and the branch outcome it generates the load-use stall, the taken-branch/jump flush and the registered forwarding selects for the EX operand muxes.
- Also maintains stall, flush and retired-instruction counters for bring-up.

Parameters:
- CNT_W, 32, width of each performance counter (counters wrap).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  IF/ID holds a real instruction
- id_rs1  in  5  source register 1 of ID instruction
- id_rs2  in  5  source register 2 of ID instruction
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_rd  in  5  destination of ID instruction
- id_wb_en  in  1  ID instruction writes the register file (write_back from control)
- id_is_load  in  1  ID instruction is a load (WB_sel==0 with write_back)
- ex_brn_tkn  in  1  EX instruction redirects the PC (branch taken or jump)
- stall  out  1  hold PC and IF/ID this cycle
- flush  out  1  kill IF/ID contents this cycle
- bubble_ex  out  1  load a NOP into ID/EX this cycle
- fwd_a_sel  out  2  EX operand A source: 0 regfile, 1 MEM-stage ALU result, 2 WB data
- fwd_b_sel  out  2  EX operand B source, same encoding
- rf_byp_a  out  1  ID rs1 must take WB data (same-cycle write/read)
- rf_byp_b  out  1  ID rs2 must take WB data
- stall_cnt  out  CNT_W  cycles with stall asserted
- flush_cnt  out  CNT_W  cycles with flush asserted
- retire_cnt  out  CNT_W  valid instructions leaving WB

Behaviour:
- Scoreboard entries EX, MEM, WB each hold {v, rd, wb, ld}.
- Every cycle the entries shift: WB<=MEM, MEM<=EX.
- EX<=ID fields when the instruction advances; EX<=invalid (v=0) when bubble_ex is asserted.
- A register is considered written by a stage only when v=1, wb=1 and rd!=0. x0 never matches, so it never stalls or forwards.
- Load-use: `lu = EX.v & EX.ld & EX.wb & EX.rd!=0 & id_valid & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd))`.
- Redirect: `redir = ex_brn_tkn & EX.v`. A redirect with EX.v=0 is ignored.
- Outputs are combinational from scoreboard and inputs:
  - redir=1: flush=1, bubble_ex=1, stall=0. Redirect has priority over load-use; the stalled ID instruction is discarded anyway.
  - lu=1 (no redir): stall=1, bubble_ex=1, flush=0. Exactly one stall cycle per load-use. The next cycle EX holds the bubble, so lu=0.
  - otherwise: all three = 0. EX takes ID fields qualified by id_valid.
- Forwarding selects are registered, one-cycle latency, and apply to the instruction that enters EX.
  - Computed at ID for operand A: 1 if EX entry writes id_rs1 and EX.ld=0; else 2 if MEM entry writes id_rs1; else 0. Operand B is identical using id_rs2.
  - MEM priority over WB when both match (youngest wins).
  - The select is forced to 0 when the operand is unused or when bubble_ex is asserted.
  - When stall=1, the selects load 0 (bubble enters EX).
- rf_byp_a/b are combinational: 1 when the WB entry writes id_rs1/id_rs2 and the operand is used.
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - flush_cnt increments on each cycle with flush=1.
  - retire_cnt increments when WB.v=1.
  - All counters wrap at 2^CNT_W.
- Reset: all entries v=0, rd=0, wb=0, ld=0; fwd_a_sel=fwd_b_sel=0; all counters 0.
- While reset is high, stall, flush and bubble_ex read 0, because the scoreboard is empty and redir requires EX.v.
- Reset asserted mid-stall clears state on the next edge; there is no residual stall.
- Simultaneous cases:
  - Load-use and redirect in the same cycle: flush only, and stall_cnt is not incremented.
  - Back-to-back redirects: each cycle with redir counts once.

Test Plan:
- Scenario 1 (ALU forwarding): `addi x5` then `add x6,x5,x5` back to back, id_wb_en=1 -> one cycle after ID issue, fwd_a_sel=fwd_b_sel=1; stall never asserted.
- Scenario 2 (load-use): `lw x7` followed by `sub x8,x7,x0` -> stall=1 and bubble_ex=1 for exactly one cycle. Next cycle, fwd_a_sel=2 when sub enters EX. stall_cnt=1.
- Scenario 3 (redirect with pending load-use): taken branch in EX (ex_brn_tkn=1, EX.v=1) while ID holds a load-use candidate -> flush=1, bubble_ex=1, stall=0. flush_cnt=1, stall_cnt=0.
- Scenario 4 (x0 and unused operands): `lw x0` then `add x9,x0,x0`, and `lui x10` (use_rs1=0) after a write to x10's rs1 field -> no stall, fwd selects 0.
- Scenario 5 (priority and same-cycle bypass): `addi x3`, `addi x3`, then `add x4,x3,x3` -> fwd selects=1 (MEM wins over WB). Separately, a WB write to x11 while ID reads x11 -> rf_byp_a=1.
- Scenario 6 (reset mid-operation): drive 10 valid instructions, check retire_cnt=10; then pulse reset during a stall -> next cycle all counters 0, stall=0, fwd selects 0.
